// File: rtl/usb_rx_decoder_if.sv
// Line-side inputs and byte-side outputs of the USB full-speed receive front end.
// The decoder is the slave. The line driver and packet consumer is the master.
interface usb_rx_decoder_if;
    logic       dplus_in;
    logic       dminus_in;
    logic [7:0] rx_data;
    logic       rx_byte_valid;
    logic       rx_active;
    logic       eop;
    logic       rx_error;

    modport master (
        output dplus_in, dminus_in,
        input  rx_data, rx_byte_valid, rx_active, eop, rx_error
    );

    modport slave (
        input  dplus_in, dminus_in,
        output rx_data, rx_byte_valid, rx_active, eop, rx_error
    );
endinterface

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder. It synchronises the lines, recovers bit timing from D+ edges,
// decodes NRZI, checks SYNC, removes stuffed bits and detects EOP. clk runs at 8x the bit rate.
module usb_rx_decoder (
    input  logic             clk,
    input  logic             n_rst,
    usb_rx_decoder_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_RECV, S_EOP1, S_EOP2, S_ERR} state_t;

    state_t     r_state;
    logic       r_dp_s1, r_dp_s2, r_dp_d, r_dm_s1, r_dm_s2;
    logic [2:0] r_cnt;
    logic       r_prev;
    logic [7:0] r_shift;
    logic [2:0] r_ones;
    logic [2:0] r_bit_idx;
    logic       r_err_se0;
    logic [7:0] r_data;
    logic       r_byte_valid, r_active, r_eop, r_error;

    logic       w_edge, w_fall, w_sample, w_se0, w_j, w_both1, w_bit;
    logic [7:0] w_shift_nx;

    assign w_edge     = r_dp_s2 ^ r_dp_d;
    assign w_fall     = w_edge & ~r_dp_s2;
    // NOTE: a sample cycle that coincides with an edge is dropped, because the bit timer restarts there.
    assign w_sample   = (r_cnt == 3'd3) & ~w_edge;
    assign w_se0      = ~r_dp_s2 & ~r_dm_s2;
    assign w_j        =  r_dp_s2 & ~r_dm_s2;
    assign w_both1    =  r_dp_s2 &  r_dm_s2;
    assign w_bit      = (r_dp_s2 == r_prev);
    assign w_shift_nx = {w_bit, r_shift[7:1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_s1 <= 1'b1;
            r_dp_s2 <= 1'b1;
            r_dp_d  <= 1'b1;
            r_dm_s1 <= 1'b0;
            r_dm_s2 <= 1'b0;
            r_cnt   <= 3'd0;
        end else begin
            r_dp_s1 <= bus.dplus_in;
            r_dp_s2 <= r_dp_s1;
            r_dp_d  <= r_dp_s2;
            r_dm_s1 <= bus.dminus_in;
            r_dm_s2 <= r_dm_s1;
            r_cnt   <= w_edge ? 3'd0 : r_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_prev       <= 1'b1;
            r_shift      <= 8'h00;
            r_ones       <= 3'd0;
            r_bit_idx    <= 3'd0;
            r_err_se0    <= 1'b0;
            r_data       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_active     <= 1'b0;
            r_eop        <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // NOTE: the strobes default low in every cycle, so each pulse lasts exactly one clock.
            r_byte_valid <= 1'b0;
            r_eop        <= 1'b0;
            if (w_sample && !w_se0)
                r_prev <= r_dp_s2;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_SYNC;
                        r_error   <= 1'b0;
                        r_active  <= 1'b1;
                        r_bit_idx <= 3'd0;
                    end
                end
                S_SYNC: begin
                    if (w_sample) begin
                        if (w_se0 || w_both1 || (w_bit != (r_bit_idx == 3'd7))) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (r_bit_idx == 3'd7) begin
                            r_state   <= S_RECV;
                            r_ones    <= 3'd1;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_sample) begin
                        if (w_both1 || (w_se0 && r_bit_idx != 3'd0) || (!w_se0 && r_ones == 3'd6 && w_bit)) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end else if (w_se0) begin
                            r_state <= S_EOP1;
                        end else if (r_ones == 3'd6) begin
                            r_ones <= 3'd0;
                        end else begin
                            r_shift   <= w_shift_nx;
                            r_ones    <= w_bit ? r_ones + 3'd1 : 3'd0;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == 3'd7) begin
                                r_data       <= w_shift_nx;
                                r_byte_valid <= 1'b1;
                            end
                        end
                    end
                end
                S_EOP1: begin
                    if (w_sample) begin
                        if (w_se0) begin
                            r_state <= S_EOP2;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_EOP2: begin
                    if (w_sample) begin
                        if (w_j) begin
                            r_state  <= S_IDLE;
                            r_eop    <= 1'b1;
                            r_active <= 1'b0;
                            r_prev   <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_ERR: begin
                    r_error <= 1'b1;
                    // Leave only after an SE0 sample is followed directly by a J sample.
                    if (w_sample) begin
                        if (w_se0) begin
                            r_err_se0 <= 1'b1;
                        end else if (w_j && r_err_se0) begin
                            r_state   <= S_IDLE;
                            r_active  <= 1'b0;
                            r_err_se0 <= 1'b0;
                        end else begin
                            r_err_se0 <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = r_data;
    assign bus.rx_byte_valid = r_byte_valid;
    assign bus.rx_active     = r_active;
    assign bus.eop           = r_eop;
    assign bus.rx_error      = r_error;
endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench for usb_rx_decoder. An NRZI line encoder drives packets.
// A scoreboard compares the received bytes with the bytes that were sent.
module tb_usb_rx_decoder;
    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE0 = 2'b00;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         nb;
        int         mode;
        int         gap;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    usb_rx_decoder_if bus();
    usb_rx_decoder dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int byte_seen = 0;
    int eop_seen = 0;
    int overlap_seen = 0;

    logic cur_dp = 1'b1;
    int   sym_idx = 0;
    int   per_mode = 0;
    vec_t vecs[6];

    always @(negedge clk) begin
        if (bus.rx_byte_valid) begin
            got_q.push_back(bus.rx_data);
            byte_seen++;
        end
        if (bus.eop) eop_seen++;
        if (bus.rx_byte_valid && bus.eop) overlap_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put_sym(input logic [1:0] s);
        int per;
        per = (per_mode == 0) ? 8 : ((sym_idx % 2 == 0) ? 7 : 9);
        {bus.dplus_in, bus.dminus_in} = s;
        sym_idx++;
        repeat (per) @(posedge clk);
    endtask

    task automatic put_bit(input logic b);
        if (!b) cur_dp = ~cur_dp;
        put_sym(cur_dp ? L_J : L_K);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) put_bit(1'b0);
        put_bit(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d, inout int ones);
        for (int i = 0; i < 8; i++) begin
            put_bit(d[i]);
            ones = d[i] ? ones + 1 : 0;
            if (ones == 6) begin
                put_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        put_sym(L_SE0);
        put_sym(L_SE0);
        cur_dp = 1'b1;
        put_sym(L_J);
    endtask

    task automatic idle(input int n);
        {bus.dplus_in, bus.dminus_in} = L_J;
        cur_dp = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic score(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_rx_data"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        int b_start, e_start, ones;
        b_start  = byte_seen;
        e_start  = eop_seen;
        per_mode = v.mode;
        sym_idx  = 0;
        exp_q.push_back(v.b0);
        if (v.nb == 2) exp_q.push_back(v.b1);
        send_sync();
        #1;
        check({tag, "_active_in_pkt"}, bus.rx_active, 1'b1);
        check({tag, "_error_in_pkt"}, bus.rx_error, 1'b0);
        ones = 1;
        send_byte(v.b0, ones);
        if (v.nb == 2) send_byte(v.b1, ones);
        send_eop();
        idle(v.gap);
        #1;
        check({tag, "_byte_count"}, byte_seen - b_start, v.nb);
        check({tag, "_eop_count"}, eop_seen - e_start, 1);
        check({tag, "_rx_error"}, bus.rx_error, 1'b0);
        check({tag, "_rx_active"}, bus.rx_active, 1'b0);
        score(tag);
    endtask

    initial begin
        int b_start, e_start;
        vec_t good12;
        vecs[0] = '{8'hA5, 8'h3C, 2, 0, 20};
        vecs[1] = '{8'hFF, 8'h00, 2, 0, 20};
        vecs[2] = '{8'hA5, 8'h00, 1, 1, 20};
        vecs[3] = '{8'h7E, 8'h81, 2, 0, 0};
        vecs[4] = '{8'hFC, 8'h3F, 2, 1, 20};
        vecs[5] = '{8'h12, 8'h00, 1, 0, 20};
        good12  = '{8'h12, 8'h00, 1, 0, 20};

        {bus.dplus_in, bus.dminus_in} = L_J;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        n_rst = 1'b1;
        idle(100);
        #1;
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_rx_active", bus.rx_active, 1'b0);
        check("reset_rx_error", bus.rx_error, 1'b0);
        check("reset_byte_strobes", byte_seen, 0);
        check("reset_eop_strobes", eop_seen, 0);

        for (int i = 0; i < 6; i++)
            run_pkt(vecs[i], $sformatf("vec%0d", i));

        // Stuff error: seven ones after SYNC with no stuffed zero.
        per_mode = 0; sym_idx = 0;
        b_start = byte_seen; e_start = eop_seen;
        send_sync();
        for (int i = 0; i < 7; i++) put_bit(1'b1);
        #1;
        check("stuff_err_flag", bus.rx_error, 1'b1);
        check("stuff_err_active", bus.rx_active, 1'b1);
        send_eop();
        idle(20);
        #1;
        check("stuff_err_idle_active", bus.rx_active, 1'b0);
        check("stuff_err_sticky", bus.rx_error, 1'b1);
        check("stuff_err_bytes", byte_seen - b_start, 0);
        check("stuff_err_eops", eop_seen - e_start, 0);
        got_q.delete();
        run_pkt(good12, "after_stuff_err");

        // Corrupted SYNC: KJKJKJKJ.
        b_start = byte_seen;
        for (int i = 0; i < 8; i++) put_bit(1'b0);
        send_eop();
        idle(20);
        #1;
        check("bad_sync_error", bus.rx_error, 1'b1);
        check("bad_sync_bytes", byte_seen - b_start, 0);
        check("bad_sync_active", bus.rx_active, 1'b0);
        got_q.delete();

        // SE0 arrives after only four data bits.
        b_start = byte_seen; e_start = eop_seen;
        send_sync();
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        send_eop();
        idle(20);
        #1;
        check("short_byte_error", bus.rx_error, 1'b1);
        check("short_byte_eops", eop_seen - e_start, 0);
        check("short_byte_bytes", byte_seen - b_start, 0);
        got_q.delete();

        // Reset asserted in the middle of a packet.
        send_sync();
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        n_rst = 1'b0;
        #1;
        check("midrst_rx_data", bus.rx_data, 8'h00);
        check("midrst_rx_active", bus.rx_active, 1'b0);
        check("midrst_rx_error", bus.rx_error, 1'b0);
        idle(10);
        n_rst = 1'b1;
        idle(20);
        got_q.delete();
        run_pkt(vecs[0], "after_midrst");

        check("strobe_overlap", overlap_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

Receive-side front end of the USB full-speed endpoint, mirroring the NRZI transmit encoder. Takes raw D+/D− line levels, synchronizes them, and recovers bit timing from line edges. Performs NRZI decoding, SYNC detection, bit unstuffing and EOP detection, then delivers assembled bytes to the RX packet controller. Runs on a clock of exactly 8× the bit rate.

## Interface
- No parameters; bit period fixed at 8 clk.
- clk  in  1  system clock, 8× bit rate
- n_rst  in  1  asynchronous, active-low reset
- dplus_in  in  1  raw D+ line, asynchronous
- dminus_in  in  1  raw D− line, asynchronous
- rx_data  out  8  last completed byte, LSB received first
- rx_byte_valid  out  1  one-cycle strobe: rx_data updated
- rx_active  out  1  high from SYNC start through EOP/error
- eop  out  1  one-cycle strobe: valid end of packet
- rx_error  out  1  sticky error flag

## Operation
- Synchronizer: two flops per line; reset values D+ = 1, D− = 0 (idle J). A third D+ flop (reset 1) feeds the edge detector.
- Edge: synced D+ differs from its delayed copy.
- Bit timer: 3-bit counter; loads 0 on an edge, otherwise increments and wraps 7→0. A sample fires when the counter equals 3.
- Line states at sample:
  - J: D+=1, D−=0
  - K: D+=0, D−=1
  - SE0: both 0
  - Both 1 is treated as an error in all non-IDLE states.
- NRZI: prev_level register, reset 1. Decoded bit = 1 if sampled D+ equals prev_level, else 0. prev_level is updated on every non-SE0 sample.
- FSM states: IDLE, SYNC, RECV, EOP1, EOP2, ERR.
- IDLE:
  - On a falling edge of synced D+ (J→K), go to SYNC, clear rx_error, and set rx_active.
  - Counter loads 0 on that edge.
- SYNC:
  - Collects 8 decoded bits, which must be 0,0,0,0,0,0,0,1 in arrival order.
  - Match: go to RECV with ones_cnt = 1 and bit_idx = 0.
  - Mismatch or SE0: go to ERR.
- RECV, per sample:
  - SE0 with bit_idx = 0 → EOP1.
  - SE0 with bit_idx ≠ 0 → ERR.
  - ones_cnt = 6 and bit = 0: stuffed bit; discard it and set ones_cnt = 0.
  - ones_cnt = 6 and bit = 1: stuff error → ERR.
  - Otherwise:
    - shift = {bit, shift[7:1]}
    - ones_cnt = bit ? ones_cnt+1 : 0
    - bit_idx++
    - On the 8th bit, load rx_data, pulse rx_byte_valid, and wrap bit_idx to 0.
- EOP1: next sample must be SE0 → EOP2; else ERR.
- EOP2: next sample must be J → pulse eop, drop rx_active, set prev_level = 1, go to IDLE; else ERR.
- ERR:
  - Set rx_error and keep rx_active high.
  - Wait for the pattern SE0 sample then J sample; then drop rx_active and go to IDLE.
  - No eop pulse is issued from ERR.
  - rx_error stays high until the next IDLE→SYNC transition.
- rx_byte_valid and eop are never both high in the same cycle.

## Timing
- Reset (any time, including mid-packet):
  - rx_data = 0x00; rx_byte_valid, rx_active, eop and rx_error = 0.
  - State IDLE, counter 0, prev_level 1, shift 0, ones_cnt 0, bit_idx 0.
- Input-to-sample latency: 2 synchronizer cycles, plus 3 cycles from the edge-detect cycle to the sample.
- All outputs are registered. rx_byte_valid and eop go high in the cycle after the sampling edge, for exactly 1 cycle.
- rx_active rises in the cycle after the J→K edge is detected. It falls together with the eop pulse, or on the exit from ERR.
- Timing recovery: any edge re-centres sampling. The decoder must tolerate bit periods of 7–9 clk across runs of up to 7 bits without an edge (6 ones plus a stuff bit).
- Back-to-back packets: a J→K edge seen one bit after an EOP2 exit starts a new SYNC.

## Test plan
- Reset, hold idle J for 100 clk → all outputs 0, no strobes.
- Send SYNC, then 0xA5, then 0x3C, then EOP at 8 clk/bit → rx_byte_valid strobes twice (rx_data 0xA5, then 0x3C); one eop strobe; rx_active high from SYNC to EOP; rx_error 0.
- Send SYNC, then 0xFF, then 0x00 with a stuffed 0 after the sixth 1 → rx_data 0xFF, then 0x00; stuffed bit not counted; no error.
- Send SYNC, then seven consecutive 1s with no stuff bit → rx_error = 1, no rx_byte_valid. After SE0,SE0,J the block is back in IDLE. A following good packet with byte 0x12 → rx_error clears at its SYNC and 0x12 is received.
- Send a corrupted SYNC (KJKJKJKJ) → rx_error = 1, no bytes. Send SE0 after 4 data bits → rx_error = 1, no eop.
- Send packet 0xA5 with bit periods alternating 7 and 9 clk → rx_data 0xA5 and eop received correctly.
